wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone B3 initiator: turns single-word commands from local logic (valid/ready) into classic Wishbone cycles on a `wb_if` `mst` modport.
- Returns one response per command (read data plus status).
- Handles slave `err`, retry on `rty`, and a cycle timeout, so an unresponsive slave cannot hang the requester.
- Used by control FSMs to reach slave register banks.

Parameters:
- ADR_W, 32, command address width; drives `adr[ADR_W-1:0]`, upper `adr` bits 0.
- DAT_W, 32, data width; drives/samples `dat[DAT_W-1:0]`, upper `dat_m2s` bits 0.
- SEL_W, DAT_W/8, byte-select width; upper `sel` bits 0.
- TIMEOUT, 255, max cycles `stb` may stay asserted without termination (1..65535).
- MAX_RETRY, 3, number of re-issues after `rty` (0 = report `rty` immediately).
- RETRY_GAP, 4, idle cycles between `rty` and re-issue (>=1).

Ports:
- clk  input  1  clock; also the clock of the attached `wb_if` instance.
- rst  input  1  reset.
- wb  interface  wb_if.mst  Wishbone master side.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when `cmd_valid & cmd_ready`.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  ADR_W  word address.
- cmd_dat  input  DAT_W  write data.
- cmd_sel  input  SEL_W  byte enables.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when `rsp_valid & rsp_ready`.
- rsp_dat  output  DAT_W  read data (0 for writes and failed cycles).
- rsp_status  output  2  00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - all outputs registered;
  - `cyc=stb=we=0`, `adr=dat_m2s=sel=0`, `cti=3'b000`, `bte=2'b00`;
  - `cmd_ready=1`, `rsp_valid=0`, `rsp_dat=0`, `rsp_status=00`, `busy=0`;
  - counters 0, state IDLE.
- `cti` and `bte` are constant 000/00 (classic cycles only, no bursts).
- States: IDLE, BUS, GAP, RESP.
- IDLE:
  - `cmd_ready=1`.
  - On accept at edge N, latch `cmd_*`.
  - At edge N, `cyc=stb=1` and `we/adr/dat_m2s/sel` become valid, so the bus is active in cycle N+1.
  - `cmd_ready=0` from edge N.
  - Next state BUS; retry count cleared.
- BUS:
  - `cyc`/`stb` and address/data held stable; timeout counter increments every cycle.
  - Termination is sampled only while `stb=1`. Priority: `err` > `ack` > `rty` (simultaneous `ack`+`err` is treated as ERR).
  - `ack`:
    - drop `cyc/stb` at the same edge;
    - `rsp_dat` = `dat_s2m[DAT_W-1:0]` if read, else 0;
    - status OK; go RESP.
    - Zero-wait slave: request in cycle N+1, `rsp_valid` in cycle N+2.
  - `err`: drop `cyc/stb`, `rsp_dat=0`, status ERR, go RESP.
  - `rty` with retries used < MAX_RETRY: drop `cyc/stb`, retry count++, go GAP.
  - `rty` with retries used == MAX_RETRY: drop `cyc/stb`, status RETRY_EXHAUSTED, `rsp_dat=0`, go RESP.
  - Timeout counter reaching TIMEOUT with no termination: drop `cyc/stb`, status TIMEOUT, `rsp_dat=0`, go RESP.
  - `stb` is high exactly TIMEOUT cycles in that case.
  - A late `ack` arriving after the drop is ignored.
- GAP:
  - `cyc=stb=0` for exactly RETRY_GAP cycles.
  - Then re-assert with identical `adr/dat/sel/we`; timeout counter cleared; go BUS.
- RESP:
  - `rsp_valid=1`; `rsp_dat`/`rsp_status` held stable until `rsp_ready`.
  - On handshake: `rsp_valid=0`, `cmd_ready=1`, go IDLE.
  - No new command is accepted in the same cycle as the response handshake (one command in flight maximum).
- `cmd_valid` while not ready is ignored; no internal queue.
- Reset mid-operation: next edge drives all reset values; in-flight command dropped, no response emitted. The slave sees `cyc` fall without termination, which is legal per B3.
- Counter widths: timeout counter 16 bits; retry count `$clog2(MAX_RETRY+1)` bits (min 1); gap counter `$clog2(RETRY_GAP+1)` bits.

Test Plan:
- Zero-wait write: cmd we=1 adr=0x10 dat=0xDEADBEEF sel=0xF; slave acks in first `stb` cycle -> `cyc/stb` high 1 cycle with those values; `rsp_valid` 2 cycles after accept; status 00; `rsp_dat` 0.
- Read with 3 wait states: slave returns 0x12345678 with `ack` on 4th `stb` cycle -> `stb` high 4 cycles; `rsp_dat`=0x12345678; status 00; `rsp_ready` held low 5 cycles -> outputs stable, `cmd_ready`=0 throughout.
- Retry: slave asserts `rty` twice, then `ack` -> three bus cycles each separated by exactly 4 idle cycles, identical `adr/dat`; status 00. Slave always `rty` -> 4 attempts total (1+MAX_RETRY), status 11.
- Error/timeout: slave asserts `ack` and `err` together -> status 01. Silent slave -> `stb` high exactly 255 cycles, then status 10; an `ack` injected 2 cycles later is ignored.
- Reset mid-cycle: assert `rst` during 2nd wait state of a read -> next edge `cyc=stb=0`, `cmd_ready=1`, `rsp_valid` never asserts; next command completes normally.
- Backpressure: `cmd_valid` held high with new data while busy -> only the first command is issued; second is accepted one cycle after the response handshake.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Wishbone B3 classic bus bundle shared by one initiator and one target.
// Upper address/data/select bits beyond the initiator's widths read as 0.
interface wb_if #(
   parameter int ADR_W = 32,
   parameter int DAT_W = 32,
   parameter int SEL_W = DAT_W / 8
) (
   input logic clk
);
   logic             cyc;
   logic             stb;
   logic             we;
   logic [ADR_W-1:0] adr;
   logic [DAT_W-1:0] dat_m2s;
   logic [DAT_W-1:0] dat_s2m;
   logic [SEL_W-1:0] sel;
   logic [2:0]       cti;
   logic [1:0]       bte;
   logic             ack;
   logic             err;
   logic             rty;

   modport mst (
      output cyc, stb, we, adr, dat_m2s, sel, cti, bte,
      input  dat_s2m, ack, err, rty
   );

   modport slv (
      input  clk, cyc, stb, we, adr, dat_m2s, sel, cti, bte,
      output dat_s2m, ack, err, rty
   );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-word command to Wishbone B3 classic cycle bridge with err/rty
// handling and a per-attempt timeout so a dead slave cannot hang the caller.
module wb_cmd_master #(
   parameter int ADR_W     = 32,
   parameter int DAT_W     = 32,
   parameter int SEL_W     = DAT_W / 8,
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3,
   parameter int RETRY_GAP = 4
) (
   input  logic             clk,
   input  logic             rst,
   wb_if.mst                wb,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [ADR_W-1:0] cmd_adr,
   input  logic [DAT_W-1:0] cmd_dat,
   input  logic [SEL_W-1:0] cmd_sel,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DAT_W-1:0] rsp_dat,
   output logic [1:0]       rsp_status,
   output logic             busy
);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;
   localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
   localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 1);
   localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;
   localparam logic [1:0] ST_RTX = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_RESP} state_t;

   state_t           state_q, state_d;
   logic             cyc_q, cyc_d;
   logic             we_q, we_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [DAT_W-1:0] dat_q, dat_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
   logic [1:0]       rsp_status_q, rsp_status_d;
   logic             busy_q, busy_d;
   logic [15:0]      tmo_q, tmo_d;
   logic [RW-1:0]    rty_cnt_q, rty_cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [DAT_W-1:0] rdat;

   assign rdat = wb.dat_s2m[DAT_W-1:0];

   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;
      tmo_d        = tmo_q;
      rty_cnt_d    = rty_cnt_q;
      gap_d        = gap_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d     = S_BUS;
               cyc_d       = 1'b1;
               we_d        = cmd_we;
               adr_d       = cmd_adr;
               dat_d       = cmd_dat;
               sel_d       = cmd_sel;
               cmd_ready_d = 1'b0;
               rty_cnt_d   = '0;
               tmo_d       = '0;
            end
         end
         S_BUS: begin
            // err wins over ack so a faulting slave is never reported OK
            if (wb.err || wb.ack || wb.rty || tmo_q == TMO_LAST) begin
               cyc_d       = 1'b0;
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = '0;
               if (wb.err) begin
                  rsp_status_d = ST_ERR;
               end else if (wb.ack) begin
                  rsp_status_d = ST_OK;
                  rsp_dat_d    = we_q ? '0 : rdat;
               end else if (wb.rty) begin
                  rsp_status_d = ST_RTX;
                  if (rty_cnt_q != RTY_MAX) begin
                     state_d     = S_GAP;
                     rsp_valid_d = 1'b0;
                     rsp_dat_d   = rsp_dat_q;
                     rsp_status_d = rsp_status_q;
                     rty_cnt_d   = rty_cnt_q + 1'b1;
                     gap_d       = '0;
                  end
               end else begin
                  rsp_status_d = ST_TMO;
               end
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               tmo_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= ST_OK;
         busy_q       <= 1'b0;
         tmo_q        <= '0;
         rty_cnt_q    <= '0;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
         busy_q       <= busy_d;
         tmo_q        <= tmo_d;
         rty_cnt_q    <= rty_cnt_d;
         gap_q        <= gap_d;
      end
   end

   always_comb begin
      wb.cyc                = cyc_q;
      wb.stb                = cyc_q;
      wb.we                 = we_q;
      wb.adr                = '0;
      wb.adr[ADR_W-1:0]     = adr_q;
      wb.dat_m2s            = '0;
      wb.dat_m2s[DAT_W-1:0] = dat_q;
      wb.sel                = '0;
      wb.sel[SEL_W-1:0]     = sel_q;
      wb.cti                = 3'b000;
      wb.bte                = 2'b00;
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_dat    = rsp_dat_q;
   assign rsp_status = rsp_status_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: scripted Wishbone slave, vector table,
// plus hand sequences for reset-in-flight and command backpressure.
module tb_wb_cmd_master;
   localparam int K_ACK  = 0;
   localparam int K_ERR  = 1;
   localparam int K_BOTH = 2;
   localparam int K_RTY  = 3;
   localparam int K_NONE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_dat;
   logic [1:0]  rsp_status;
   logic        busy;

   wb_if #(.ADR_W(32), .DAT_W(32), .SEL_W(4)) wb (.clk(clk));

   wb_cmd_master dut (
      .clk(clk), .rst(rst), .wb(wb.mst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_status(rsp_status), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // scripted slave
   int          sl_kind = K_ACK, sl_waits = 0, sl_rty_n = 0;
   logic [31:0] sl_rdata = '0;
   logic        inj_ack = 1'b0;
   int          s_cnt = 0, s_att = 0;

   always_comb begin
      wb.ack     = inj_ack;
      wb.err     = 1'b0;
      wb.rty     = 1'b0;
      wb.dat_s2m = sl_rdata;
      if (wb.cyc && wb.stb && s_cnt == sl_waits) begin
         case (sl_kind)
            K_ACK:  wb.ack = 1'b1;
            K_ERR:  wb.err = 1'b1;
            K_BOTH: begin wb.ack = 1'b1; wb.err = 1'b1; end
            K_RTY:  if (s_att < sl_rty_n) wb.rty = 1'b1; else wb.ack = 1'b1;
            default: ;
         endcase
      end
   end

   always @(posedge clk) begin
      if (rst || !busy) begin
         s_cnt <= 0;
         s_att <= 0;
      end else if (wb.stb) begin
         if (wb.rty) s_att <= s_att + 1;
         if (wb.ack || wb.err || wb.rty) s_cnt <= 0;
         else s_cnt <= s_cnt + 1;
      end
   end

   // bus monitor, sampled on the falling edge
   int          cmd_id = 0, seen_id = 0;
   logic        e_we;
   logic [31:0] e_adr, e_dat;
   logic [3:0]  e_sel;
   logic        prev_stb = 1'b0;
   int          att = 0, stb_cnt = 0, idle_run = 0, bad = 0;
   int          gap_min = 1000, gap_max = 0;
   logic [31:0] last_adr = '0;

   always @(negedge clk) begin
      if (seen_id != cmd_id) begin
         seen_id  = cmd_id;
         att      = 0;
         stb_cnt  = 0;
         idle_run = 0;
         bad      = 0;
         gap_min  = 1000;
         gap_max  = 0;
      end
      if (wb.stb) begin
         if (!prev_stb) begin
            if (att > 0) begin
               if (idle_run < gap_min) gap_min = idle_run;
               if (idle_run > gap_max) gap_max = idle_run;
            end
            att      = att + 1;
            idle_run = 0;
            last_adr = wb.adr;
         end
         stb_cnt = stb_cnt + 1;
         if (!wb.cyc || wb.we !== e_we || wb.adr !== e_adr ||
             wb.dat_m2s !== e_dat || wb.sel !== e_sel)
            bad = bad + 1;
      end else begin
         idle_run = idle_run + 1;
      end
      prev_stb = wb.stb;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int acc);
      bit ok = 0;
      e_we = we; e_adr = adr; e_dat = dat; e_sel = sel;
      cmd_id++;
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      cmd_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (cmd_ready) ok = 1;
         @(posedge clk); #1;
      end
      acc = cyc_n;
      cmd_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout actual=0 required=1");
      end
   endtask

   task automatic wait_rsp(output int r);
      bit ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (rsp_valid) ok = 1;
         else begin @(posedge clk); #1; end
      end
      r = cyc_n;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rsp_timeout actual=0 required=1");
      end
   endtask

   task automatic handshake;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          kind;
      int          waits;
      int          rty_n;
      logic [31:0] rdata;
      logic [1:0]  st;
      logic [31:0] rd;
      int          stb_n;
      int          att_n;
      int          lat;
      int          dly;
      bit          inj;
   } vec_t;

   vec_t vt[8];
   int   acc, rsp_e, unstable, hs_e, cnt;

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, K_ACK,  0, 0,  32'h55555555,
                2'b00, 32'h0, 1, 1, 1, 0, 1'b0};
      vt[1] = '{1'b0, 32'h20, 32'h0, 4'hF, K_ACK,  3, 0,  32'h12345678,
                2'b00, 32'h12345678, 4, 1, 4, 5, 1'b0};
      vt[2] = '{1'b1, 32'h30, 32'hA5A5A5A5, 4'h3, K_RTY, 0, 2, 32'h0,
                2'b00, 32'h0, 3, 3, 11, 0, 1'b0};
      vt[3] = '{1'b0, 32'h34, 32'h0, 4'hF, K_RTY,  0, 99, 32'h77777777,
                2'b11, 32'h0, 4, 4, 16, 1, 1'b0};
      vt[4] = '{1'b0, 32'h38, 32'h0, 4'hF, K_BOTH, 0, 0,  32'h11112222,
                2'b01, 32'h0, 1, 1, 1, 0, 1'b0};
      vt[5] = '{1'b0, 32'h3C, 32'h0, 4'hF, K_ERR,  2, 0,  32'h33334444,
                2'b01, 32'h0, 3, 1, 3, 0, 1'b0};
      vt[6] = '{1'b0, 32'h44, 32'h0, 4'hF, K_NONE, 0, 0,  32'h99998888,
                2'b10, 32'h0, 255, 1, 255, 4, 1'b1};
      vt[7] = '{1'b0, 32'h48, 32'h0, 4'h3, K_ACK,  1, 0,  32'hA5A5C3C3,
                2'b00, 32'hA5A5C3C3, 2, 1, 2, 2, 1'b0};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cyc", {31'b0, wb.cyc}, 32'd0);
      chk("rst_stb", {31'b0, wb.stb}, 32'd0);
      chk("rst_adr", wb.adr, 32'd0);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_dat", rsp_dat, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_cti_bte", {27'b0, wb.cti, wb.bte}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 8; v++) begin
         sl_kind = vt[v].kind; sl_waits = vt[v].waits;
         sl_rty_n = vt[v].rty_n; sl_rdata = vt[v].rdata;
         do_cmd(vt[v].we, vt[v].adr, vt[v].dat, vt[v].sel, acc);
         wait_rsp(rsp_e);
         unstable = 0;
         for (int k = 0; k < vt[v].dly; k++) begin
            inj_ack = vt[v].inj && (k == 1);
            if (!rsp_valid || rsp_dat !== vt[v].rd ||
                rsp_status !== vt[v].st || cmd_ready)
               unstable++;
            @(posedge clk); #1;
         end
         inj_ack = 1'b0;
         chk($sformatf("v%0d_status", v), {30'b0, rsp_status}, {30'b0, vt[v].st});
         chk($sformatf("v%0d_rsp_dat", v), rsp_dat, vt[v].rd);
         chk($sformatf("v%0d_stb_cycles", v), stb_cnt, vt[v].stb_n);
         chk($sformatf("v%0d_attempts", v), att, vt[v].att_n);
         chk($sformatf("v%0d_bus_fields", v), bad, 32'd0);
         chk($sformatf("v%0d_latency", v), rsp_e - acc, vt[v].lat);
         chk($sformatf("v%0d_hold", v), unstable, 32'd0);
         if (vt[v].att_n > 1) begin
            chk($sformatf("v%0d_gap_min", v), gap_min, 32'd4);
            chk($sformatf("v%0d_gap_max", v), gap_max, 32'd4);
         end
         handshake();
         chk($sformatf("v%0d_rsp_drop", v), {31'b0, rsp_valid}, 32'd0);
         chk($sformatf("v%0d_ready_back", v), {31'b0, cmd_ready}, 32'd1);
         chk($sformatf("v%0d_idle", v), {31'b0, busy}, 32'd0);
      end

      // reset during the second wait state of a read
      sl_kind = K_ACK; sl_waits = 10; sl_rdata = 32'hBAD0BAD0;
      do_cmd(1'b0, 32'h80, 32'h0, 4'hF, acc);
      @(posedge clk); #1;
      chk("mid_stb_before_rst", {31'b0, wb.stb}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_cyc", {31'b0, wb.cyc}, 32'd0);
      chk("mid_rst_stb", {31'b0, wb.stb}, 32'd0);
      chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (rsp_valid) cnt++;
         @(posedge clk); #1;
      end
      chk("mid_rst_no_rsp", cnt, 32'd0);
      sl_waits = 0; sl_rdata = 32'hCAFEF00D;
      do_cmd(1'b0, 32'h84, 32'h0, 4'hF, acc);
      wait_rsp(rsp_e);
      chk("post_rst_status", {30'b0, rsp_status}, 32'd0);
      chk("post_rst_dat", rsp_dat, 32'hCAFEF00D);
      chk("post_rst_latency", rsp_e - acc, 32'd1);
      handshake();

      // second command held valid while the first is in flight
      sl_kind = K_ACK; sl_waits = 2; sl_rdata = 32'h0;
      do_cmd(1'b1, 32'h40, 32'h1, 4'hF, acc);
      cmd_we = 1'b1; cmd_adr = 32'h44; cmd_dat = 32'h2; cmd_sel = 4'hF;
      cmd_valid = 1'b1;
      wait_rsp(rsp_e);
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         if (cmd_ready) cnt++;
         @(posedge clk); #1;
      end
      chk("bp_ready_low", cnt, 32'd0);
      handshake();
      hs_e = cyc_n;
      chk("bp_first_only", att, 32'd1);
      chk("bp_first_adr", last_adr, 32'h40);
      chk("bp_no_accept_at_hs", {31'b0, busy}, 32'd0);
      e_we = 1'b1; e_adr = 32'h44; e_dat = 32'h2; e_sel = 4'hF;
      cmd_id++;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("bp_accept_edge", cyc_n - hs_e, 32'd1);
      chk("bp_second_stb", {31'b0, wb.stb}, 32'd1);
      chk("bp_second_adr", wb.adr, 32'h44);
      wait_rsp(rsp_e);
      chk("bp_second_status", {30'b0, rsp_status}, 32'd0);
      chk("bp_second_fields", bad, 32'd0);
      handshake();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
